uart_rx_frame_check: RTL
========================

Name: uart_rx_frame_check

Overview:
- Parametrised successor to the single-bit UART RX start checker.
- Consumes one mid-bit sample per received bit from the RX data sampler and validates the whole frame: start, data (LSB first), optional parity and 1 or 2 stop bits.
- Delivers the received word with a valid pulse, per-error pulses, and saturating error counters.
- Sits between the RX data sampler / edge-bit counter and the RX output register in the UART RX top.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- ERR_CNT_W, 8, width of each saturating error counter; legal 1..16.

Ports:
- CLK_FRAME_CHECK  input  1  block clock.
- RST_FRAME_CHECK  input  1  synchronous active-high reset.
- bit_valid  input  1  one-cycle strobe; sampled_bit is valid this cycle.
- sampled_bit  input  1  majority-voted mid-bit sample.
- par_en  input  1  parity present in frame; captured at start-bit acceptance.
- par_typ  input  1  0 = even, 1 = odd; captured at start-bit acceptance.
- abort  input  1  synchronous frame abort from the RX controller.
- cnt_clr  input  1  clears all three error counters.
- busy  output  1  frame in progress.
- data_out  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse, good frame.
- strt_glitch  output  1  one-cycle pulse, start sample was 1.
- par_err  output  1  one-cycle pulse, parity mismatch.
- stp_err  output  1  one-cycle pulse, stop sample was 0.
- glitch_cnt, par_err_cnt, stp_err_cnt  output  ERR_CNT_W each  saturating error counts.

Behaviour:
- Reset: the synchronous, active-high RST_FRAME_CHECK sets all outputs, counters, the shift register and the FSM to 0 / IDLE. Reset mid-frame discards the frame with no pulses.
- FSM states: IDLE, DATA, PARITY, STOP. State advances only on bit_valid.
- IDLE, bit_valid, sampled_bit=0:
  - capture par_en and par_typ;
  - clear the bit counter and running parity;
  - go to DATA; busy=1 from the next cycle.
- IDLE, bit_valid, sampled_bit=1: strt_glitch pulses next cycle, glitch_cnt increments, stay in IDLE.
- DATA:
  - each bit_valid shifts sampled_bit in LSB first and XORs it into the running parity;
  - after DATA_WIDTH bits, go to PARITY if the captured par_en=1, else STOP.
- PARITY, bit_valid: expected bit = running parity XOR captured par_typ. A mismatch sets an internal frame-error flag, pulses par_err next cycle and increments par_err_cnt. Go to STOP either way.
- STOP, bit_valid, sampled_bit=0: stp_err pulses next cycle, stp_err_cnt increments, go to IDLE immediately; with STOP_BITS=2 the second stop bit is not evaluated.
- STOP, bit_valid, sampled_bit=1:
  - if more stop bits remain, stay in STOP;
  - on the last stop bit, go to IDLE. If the frame-error flag is clear, load data_out from the shift register and pulse data_valid next cycle.
- data_out changes only on a good frame; it holds through errors, aborts and glitches.
- Latency: every pulse output asserts exactly one cycle after the bit_valid that caused it, for exactly one cycle.
- busy falls in the same cycle as the data_valid/stp_err pulse.
- abort: the FSM goes to IDLE next cycle and busy=0. No pulses and no counter increments. abort has priority over a simultaneous bit_valid. Already-scheduled pulses still fire.
- Counters: saturate at all-ones with no wrap. cnt_clr zeroes all three next cycle and wins over a simultaneous increment.
- bit_valid on back-to-back cycles is legal; each strobe is one bit.
- par_en and par_typ changing mid-frame have no effect on the current frame.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - the DATA_WIDTH and STOP_BITS legal-range checks.
- One sub-module, uart_sat_counter (parameter W; inputs inc and clr; output cnt), saturating with clr priority. Instantiated three times.

Test Plan (DATA_WIDTH=8 unless stated):
- Good frame: par_en=1, par_typ=0, bits 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop) -> data_out=0xA5, one data_valid pulse the cycle after the stop strobe, no error pulses, busy 1 -> 0.
- Start glitch: first sample 1 -> strt_glitch pulse one cycle later, glitch_cnt=1, busy stays 0, data_out unchanged.
- Parity error: as the good frame but with parity bit 1 -> par_err pulse, par_err_cnt=1, no data_valid, data_out keeps its prior value. Odd parity, data 0x00, parity bit 1 -> good frame.
- Stop error: STOP_BITS=2, par_en=0, 0x3C, stops 1,0 -> stp_err pulse after the second stop; with stops 0,x -> stp_err after the first stop and FSM in IDLE.
- Saturation and clear: ERR_CNT_W=2, five glitches -> glitch_cnt=3; cnt_clr together with a glitch strobe -> glitch_cnt=0.
- Abort and reset mid-frame: abort after data bit 3 -> IDLE, busy=0, no pulses, next frame 0x5A received correctly. RST_FRAME_CHECK asserted after bit 5 -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration-time parameter checks for the UART RX frame path.
// Holds the frame-check FSM encoding and the parity-type constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic bit data_width_legal(input int w);
        return (w >= 5) && (w <= 9);
    endfunction

    function automatic bit stop_bits_legal(input int s);
        return (s == 1) || (s == 2);
    endfunction

    function automatic bit err_cnt_w_legal(input int w);
        return (w >= 1) && (w <= 16);
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter; clr beats inc, and the count sticks at all-ones.
module uart_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// Validates a UART frame one mid-bit sample at a time (start, LSB-first data,
// optional parity, stop bits) and reports the word, error pulses and error counts.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK_FRAME_CHECK,
    input  logic                  RST_FRAME_CHECK,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  abort,
    input  logic                  cnt_clr,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [ERR_CNT_W-1:0]  glitch_cnt,
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  stp_err_cnt,
    output logic [1:0]            dbg_state
);

    if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
        $error("uart_rx_frame_check: DATA_WIDTH must be 5..9");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("uart_rx_frame_check: STOP_BITS must be 1 or 2");
    end
    if (!err_cnt_w_legal(ERR_CNT_W)) begin : g_bad_err_cnt_w
        $error("uart_rx_frame_check: ERR_CNT_W must be 1..16");
    end

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP_IDX = 1'(STOP_BITS - 1);

    rx_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  run_par_q, run_par_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  frame_err_q, frame_err_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  dv_q, dv_d;
    logic                  glitch_q, glitch_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  exp_par;

    // Expected parity bit: even parity repeats the data XOR, odd parity inverts it.
    assign exp_par = (par_typ_q == PAR_ODD) ? ~run_par_q : run_par_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        run_par_d   = run_par_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        frame_err_d = frame_err_q;
        stop_cnt_d  = stop_cnt_q;
        dv_d        = 1'b0;
        glitch_d    = 1'b0;
        perr_d      = 1'b0;
        serr_d      = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!sampled_bit) begin
                        par_en_d    = par_en;
                        par_typ_d   = par_typ;
                        bit_cnt_d   = '0;
                        run_par_d   = 1'b0;
                        frame_err_d = 1'b0;
                        stop_cnt_d  = 1'b0;
                        state_d     = DATA;
                    end else begin
                        glitch_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    run_par_d = run_par_q ^ sampled_bit;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_DATA_IDX) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sampled_bit != exp_par) begin
                        frame_err_d = 1'b1;
                        perr_d      = 1'b1;
                    end
                    state_d = STOP;
                end
                STOP: begin
                    if (!sampled_bit) begin
                        serr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (stop_cnt_q == LAST_STOP_IDX) begin
                        state_d = IDLE;
                        if (!frame_err_q) begin
                            data_d = shift_q;
                            dv_d   = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_FRAME_CHECK) begin
        if (RST_FRAME_CHECK) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            run_par_q   <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop_cnt_q  <= 1'b0;
            dv_q        <= 1'b0;
            glitch_q    <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            run_par_q   <= run_par_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            frame_err_q <= frame_err_d;
            stop_cnt_q  <= stop_cnt_d;
            dv_q        <= dv_d;
            glitch_q    <= glitch_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
        end
    end

    // Counters see the same next-cycle strobes as the pulse outputs, so both move together.
    uart_sat_counter #(.W(ERR_CNT_W)) u_glitch_cnt (
        .clk (CLK_FRAME_CHECK),
        .rst (RST_FRAME_CHECK),
        .inc (glitch_d),
        .clr (cnt_clr),
        .cnt (glitch_cnt)
    );

    uart_sat_counter #(.W(ERR_CNT_W)) u_par_err_cnt (
        .clk (CLK_FRAME_CHECK),
        .rst (RST_FRAME_CHECK),
        .inc (perr_d),
        .clr (cnt_clr),
        .cnt (par_err_cnt)
    );

    uart_sat_counter #(.W(ERR_CNT_W)) u_stp_err_cnt (
        .clk (CLK_FRAME_CHECK),
        .rst (RST_FRAME_CHECK),
        .inc (serr_d),
        .clr (cnt_clr),
        .cnt (stp_err_cnt)
    );

    assign busy        = (state_q != IDLE);
    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign strt_glitch = glitch_q;
    assign par_err     = perr_q;
    assign stp_err     = serr_q;
    assign dbg_state   = state_q;

endmodule
